// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  // Layers per pipeline group, rounded up so the last group takes the remainder.
  function automatic int unsigned layers_per_stage(input int unsigned shamt_w,
                                                   input int unsigned stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_layer_group.sv
// Combinational group of consecutive barrel-shifter layers; layer k shifts by 2^k
// when amt[k] is set and records the last bit shifted out as the carry.
module shift_layer_group
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHAMT_W     = $clog2(WIDTH),
  parameter int unsigned FIRST_LAYER = 0,
  parameter int unsigned NUM_LAYERS  = 1
) (
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] amt,
  input  shift_op_t          op,
  input  logic               sign,
  input  logic               carry_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out
);

  logic unused_inputs;
  assign unused_inputs = ^{amt, op, sign};

  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if ((amt & (SHAMT_W'(1) << (FIRST_LAYER + i))) != '0) begin
        unique case (op)
          OP_LSL: begin
            carry_out = |(data_out & (WIDTH'(1) << (WIDTH - (1 << (FIRST_LAYER + i)))));
            data_out  = data_out << (1 << (FIRST_LAYER + i));
          end
          OP_LSR: begin
            carry_out = |(data_out & (WIDTH'(1) << ((1 << (FIRST_LAYER + i)) - 1)));
            data_out  = data_out >> (1 << (FIRST_LAYER + i));
          end
          OP_ASR: begin
            carry_out = |(data_out & (WIDTH'(1) << ((1 << (FIRST_LAYER + i)) - 1)));
            data_out  = (data_out >> (1 << (FIRST_LAYER + i))) |
                        ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> (1 << (FIRST_LAYER + i))));
          end
          OP_ROR: begin
            carry_out = |(data_out & (WIDTH'(1) << ((1 << (FIRST_LAYER + i)) - 1)));
            data_out  = (data_out >> (1 << (FIRST_LAYER + i))) |
                        (data_out << (WIDTH - (1 << (FIRST_LAYER + i))));
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with valid/ready handshake, tag passthrough
// and carry-out; each layer group is followed by a register bank.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned LPS = layers_per_stage(SHAMT_W, STAGES);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]   data_q  [STAGES];
  logic [SHAMT_W-1:0] amt_q   [STAGES];
  shift_op_t          op_q    [STAGES];
  logic               sign_q  [STAGES];
  logic               carry_q [STAGES];
  logic [TAG_W-1:0]   tag_q   [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned FIRST = s * LPS;
    localparam int unsigned NUM   = (FIRST >= SHAMT_W) ? 0 :
                                    ((SHAMT_W - FIRST < LPS) ? (SHAMT_W - FIRST) : LPS);

    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_amt;
    shift_op_t          src_op;
    logic               src_sign;
    logic               src_carry;
    logic               src_valid;
    logic [TAG_W-1:0]   src_tag;
    logic [WIDTH-1:0]   grp_data;
    logic               grp_carry;

    if (s == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_amt   = in_amt;
      assign src_op    = shift_op_t'(in_op);
      assign src_sign  = in_data[WIDTH-1];
      assign src_carry = 1'b0;
      assign src_tag   = in_tag;
    end else begin : g_src
      assign src_valid = valid_q[s-1];
      assign src_data  = data_q[s-1];
      assign src_amt   = amt_q[s-1];
      assign src_op    = op_q[s-1];
      assign src_sign  = sign_q[s-1];
      assign src_carry = carry_q[s-1];
      assign src_tag   = tag_q[s-1];
    end

    // A stage may load unless it and every stage after it are full with no output drain.
    assign load[s] = out_ready || !(&valid_q[STAGES-1:s]);

    shift_layer_group #(
      .WIDTH      (WIDTH),
      .SHAMT_W    (SHAMT_W),
      .FIRST_LAYER(FIRST),
      .NUM_LAYERS (NUM)
    ) u_group (
      .data_in  (src_data),
      .amt      (src_amt),
      .op       (src_op),
      .sign     (src_sign),
      .carry_in (src_carry),
      .data_out (grp_data),
      .carry_out(grp_carry)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        amt_q[s]   <= '0;
        op_q[s]    <= OP_LSL;
        sign_q[s]  <= 1'b0;
        carry_q[s] <= 1'b0;
        tag_q[s]   <= '0;
      end else if (load[s]) begin
        valid_q[s] <= src_valid;
        data_q[s]  <= grp_data;
        amt_q[s]   <= src_amt;
        op_q[s]    <= src_op;
        sign_q[s]  <= src_sign;
        carry_q[s] <= grp_carry;
        tag_q[s]   <= src_tag;
      end
    end
  end

  // Control fields of the final bank have no consumer beyond the pipe.
  logic unused_tail;
  assign unused_tail = ^{amt_q[STAGES-1], op_q[STAGES-1], sign_q[STAGES-1]};

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined barrel shifter for the SimpleRisc ALU/execute path. It supports LSL, LSR, ASR and ROR at configurable data width and pipeline depth. Operands enter over a valid/ready handshake and travel with a passthrough tag. Results leave with a carry-out flag and full backpressure support, which lets the shifter sit in a multi-cycle execute unit without stalling the whole datapath.

Parameters:
WIDTH, 32, data width in bits; power of two, 8..64
SHAMT_W, $clog2(WIDTH), shift-amount width (derived; not overridden)
STAGES, 2, register stages; 1..SHAMT_W; latency in cycles
TAG_W, 5, width of the opaque tag carried alongside the operand (e.g. destination register)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  shifter can accept operand this cycle
in_data  input  WIDTH  value to shift
in_amt  input  SHAMT_W  shift amount, 0..WIDTH-1
in_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
in_tag  input  TAG_W  passthrough tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_carry  output  1  last bit shifted out
out_tag  output  TAG_W  tag of the result

Behaviour:
- One clock `clk`; synchronous active-high `reset`. On reset: all stage valid bits = 0, out_valid = 0, out_data = 0, out_carry = 0, out_tag = 0. in_ready is 1 from the first cycle after reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Datapath:
  - The datapath has SHAMT_W layers; layer k shifts by 2^k when in_amt[k] = 1.
  - Layers split into STAGES groups. Each group holds ceil(SHAMT_W/STAGES) layers; the last group holds the remainder.
  - A register bank follows each group and holds data, amt, op, tag, carry and valid.
- Latency: exactly STAGES cycles from input transfer to out_valid with no backpressure. Throughput is one operation per cycle.
- Stage advance rule: stage i loads when stage i is empty OR stage i is being drained in the same cycle. The last stage drains on an output transfer. in_ready = stage-0 load condition.
  - Back-to-back flow with out_ready held high inserts no bubbles.
  - in_ready is not combinationally dependent on in_valid.
- Backpressure:
  - While out_ready = 0 and the pipe is full, all registers hold and in_ready = 0.
  - Outputs stay stable while out_valid && !out_ready.
- Fill rules per op:
  - LSL: zero fill from the LSB side.
  - LSR: zero fill from the MSB side.
  - ASR: fills with the original in_data[WIDTH-1], which is carried down the pipe.
  - ROR: wraps bits around.
- Carry (computed from the original operand):
  - amt = 0: carry = 0.
  - LSL: carry = in_data[WIDTH-amt].
  - LSR, ASR, ROR: carry = in_data[amt-1].
- Boundaries:
  - amt = 0 returns in_data unchanged for every op.
  - amt = WIDTH-1 is the maximum shift.
  - Larger shifts are the caller's responsibility; the upper bits of the architectural amount are truncated before entry.
- Reset mid-operation flushes all in-flight operations; no result is produced for them.
- Output data is registered; no combinational path from in_* to out_*.

Decomposition:
- Package `shift_pkg`:
  - typedef `shift_op_t` with values OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11.
  - Function `layers_per_stage(SHAMT_W, STAGES)`.
- Sub-module `shift_layer_group` (combinational):
  - Parameters WIDTH, FIRST_LAYER, NUM_LAYERS.
  - Inputs data, amt, op, sign, carry; outputs data and carry.
  - `pipelined_shifter` instantiates it STAGES times with the register banks and handshake between instances.

Test Plan:
1. WIDTH=32, STAGES=2: LSL 0x0000_0001 by 31 -> out_data 0x8000_0000, out_carry 0; out_valid exactly 2 cycles after input transfer.
2. ASR 0x8000_0000 by 4 -> 0xF800_0000, carry 0. LSR same operand by 4 -> 0x0800_0000. ASR 0x7FFF_FFFF by 31 -> 0x0000_0000, carry 1.
3. ROR 0x1234_5678 by 8 -> 0x7812_3456, carry 0. ROR 0x0000_0001 by 1 -> 0x8000_0000, carry 1. amt = 0, any op -> data unchanged, carry 0.
4. Stream 8 ops with tags 0..7, out_ready = 1 -> 8 results in order on 8 consecutive cycles, no bubbles, tags preserved.
5. Hold out_ready = 0 with the pipe full -> in_ready = 0 after 2 accepted ops; out_data/out_tag stable. Release -> results drain in order, none lost or duplicated.
6. Assert reset for 1 cycle with 2 ops in flight -> out_valid = 0 and out_data = 0 next cycle, in_ready = 1, no stale result appears. Repeat test 4 with STAGES = 1 and STAGES = 5 -> latencies 1 and 5, identical results.
